mdio_master: RTL and testbench

MDIO_MASTER -- requirements
Module: mdio_master

---
 rtl/mdio_master.sv | 158 +++++++++++++++
 tb/tb_mdio_master.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_master.sv
// Clause-22 MDIO management master: frames one read or write per request, MDC derived from clk.
// Optional `MDIO_PREAMBLE_SKIP_EN drops the 32-bit preamble on every frame after the first since reset.
module mdio_master #(
    parameter int unsigned CLK_DIV  = 4,
    parameter logic [4:0]  PHY_ADDR = 5'd1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [4:0]  req_reg,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, DONE} state_t;

    localparam logic [8:0] HALF = 9'(CLK_DIV - 1);
    localparam logic [8:0] LAST = 9'(2 * CLK_DIV - 1);

    state_t      state;
    state_t      nxt_state;
    logic [8:0]  div_cnt;
    logic [4:0]  bit_cnt;
    logic [4:0]  nxt_bit;
    logic        last_bit;
    logic        lat_write;
    logic [4:0]  lat_reg;
    logic [15:0] lat_wdata;
    logic [15:0] shift;
    logic        ta_err;
`ifdef MDIO_PREAMBLE_SKIP_EN
    logic        first_done;
`endif

    assign req_ready = (state == IDLE);

    // Returns {oe, o} for bit idx of the given phase.
    function automatic logic [1:0] bit_drive(input state_t st, input logic [4:0] idx,
                                             input logic wr, input logic [4:0] rg,
                                             input logic [15:0] wd);
        logic [13:0] hdr;
        hdr = {2'b01, (wr ? 2'b01 : 2'b10), PHY_ADDR, rg};
        case (st)
            PRE:     bit_drive = 2'b11;
            HDR:     bit_drive = {1'b1, hdr[4'd13 - idx[3:0]]};
            TA:      bit_drive = wr ? {1'b1, ~idx[0]} : 2'b01;
            DATA:    bit_drive = wr ? {1'b1, wd[4'd15 - idx[3:0]]} : 2'b01;
            default: bit_drive = 2'b01;
        endcase
    endfunction

    always_comb begin
        last_bit  = 1'b0;
        nxt_state = state;
        case (state)
            PRE:  begin last_bit = (bit_cnt == 5'd31); nxt_state = HDR;  end
            HDR:  begin last_bit = (bit_cnt == 5'd13); nxt_state = TA;   end
            TA:   begin last_bit = (bit_cnt == 5'd1);  nxt_state = DATA; end
            DATA: begin last_bit = (bit_cnt == 5'd15); nxt_state = DONE; end
            default: ;
        endcase
        if (!last_bit)
            nxt_state = state;
        nxt_bit = last_bit ? '0 : 5'(bit_cnt + 5'd1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            mdc       <= 1'b0;
            mdio_o    <= 1'b1;
            mdio_oe   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            lat_write <= 1'b0;
            lat_reg   <= '0;
            lat_wdata <= '0;
            shift     <= '0;
            ta_err    <= 1'b0;
`ifdef MDIO_PREAMBLE_SKIP_EN
            first_done <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    mdc     <= 1'b0;
                    mdio_oe <= 1'b0;
                    mdio_o  <= 1'b1;
                    if (req_valid) begin
                        lat_write <= req_write;
                        lat_reg   <= req_reg;
                        lat_wdata <= req_wdata;
                        div_cnt   <= '0;
                        bit_cnt   <= '0;
                        shift     <= '0;
                        ta_err    <= 1'b0;
                        mdio_oe   <= 1'b1;
`ifdef MDIO_PREAMBLE_SKIP_EN
                        // ST's first bit is 0, so a preamble-less frame starts low.
                        state  <= first_done ? HDR : PRE;
                        mdio_o <= ~first_done;
`else
                        state  <= PRE;
                        mdio_o <= 1'b1;
`endif
                    end
                end
                DONE: begin
                    // Response registers load on the DONE->IDLE edge; the pulse lands in the first IDLE cycle.
                    state     <= IDLE;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= lat_write ? '0 : shift;
                    rsp_err   <= ~lat_write & ta_err;
`ifdef MDIO_PREAMBLE_SKIP_EN
                    first_done <= 1'b1;
`endif
                end
                default: begin
                    if (div_cnt == HALF) begin
                        mdc     <= 1'b1;
                        div_cnt <= div_cnt + 9'd1;
                        if (!lat_write) begin
                            if (state == TA && bit_cnt == 5'd1)
                                ta_err <= mdio_i;
                            if (state == DATA)
                                shift <= {shift[14:0], mdio_i};
                        end
                    end else if (div_cnt == LAST) begin
                        div_cnt <= '0;
                        mdc     <= 1'b0;
                        bit_cnt <= nxt_bit;
                        state   <= nxt_state;
                        if (nxt_state == DONE)
                            {mdio_oe, mdio_o} <= 2'b01;
                        else
                            {mdio_oe, mdio_o} <= bit_drive(nxt_state, nxt_bit, lat_write,
                                                           lat_reg, lat_wdata);
                    end else begin
                        div_cnt <= div_cnt + 9'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_master.sv
// Scoreboard bench for mdio_master: expected frames are queued at request time and checked on rsp_valid.
// Build with +define+MDIO_PREAMBLE_SKIP_EN to check the preamble-skip variant.
module tb_mdio_master;

    localparam int unsigned CLK_DIV = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [4:0]  req_reg = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        mdc;
    logic        mdio_o;
    logic        mdio_oe;
    logic        mdio_i = 1'b1;

    mdio_master #(.CLK_DIV(CLK_DIV), .PHY_ADDR(5'd1)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_reg(req_reg), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mdc(mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe), .mdio_i(mdio_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int unsigned lat;
        int unsigned nbits;
        logic [63:0] exp_o;
        logic [63:0] mask_o;
        logic [63:0] exp_oe;
    } exp_t;

    exp_t        sb[$];
    exp_t        got;
    int unsigned tests = 0;
    int unsigned fails = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          last_acc_cyc = 0;
    int          last_rsp_cyc = 0;
    logic [63:0] ov = '0;
    logic [63:0] ooe = '0;
    int unsigned k = 0;
    logic        mdc_prev = 1'b0;
    logic        phy_en = 1'b0;
    logic [63:0] phy_pat = '1;
    int unsigned pre_off = 0;
    logic        first_frame = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor and PHY model; everything is sampled and driven mid-cycle.
    always @(negedge clk) begin
        if (!rstn) begin
            mdc_prev = 1'b0;
            k        = 0;
            mdio_i   = 1'b1;
        end else begin
            if (rsp_valid) begin
                last_rsp_cyc = cyc;
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    got = sb.pop_front();
                    check("rsp_rdata", 64'(rsp_rdata), 64'(got.rdata));
                    check("rsp_err", 64'(rsp_err), 64'(got.err));
                    check("latency", 64'(cyc - acc_cyc), 64'(got.lat));
                    check("frame_bits", 64'(k), 64'(got.nbits));
                    check("mdio_o_stream", ov & got.mask_o, got.exp_o & got.mask_o);
                    check("mdio_oe_stream", ooe, got.exp_oe);
                end
            end
            if (mdc && !mdc_prev) begin
                ov  = {ov[62:0], mdio_o};
                ooe = {ooe[62:0], mdio_oe};
                k++;
            end
            mdc_prev = mdc;
            if (req_valid && req_ready) begin
                acc_cyc      = cyc + 1;
                last_acc_cyc = acc_cyc;
                ov  = '0;
                ooe = '0;
                k   = 0;
            end
            if (!mdc)
                mdio_i = (phy_en && (k + pre_off) < 64) ? phy_pat[63 - (k + pre_off)] : 1'b1;
        end
    end

    task automatic push_exp(input logic wr, input logic [4:0] rg, input logic [15:0] wd,
                            input logic pen, input logic ta, input logic [15:0] pd);
        exp_t        e;
        logic        full;
        logic [13:0] hdr;
        logic [31:0] pre;
`ifdef MDIO_PREAMBLE_SKIP_EN
        full = first_frame;
`else
        full = 1'b1;
`endif
        first_frame = 1'b0;
        pre = full ? 32'hFFFF_FFFF : 32'h0;
        hdr = {2'b01, (wr ? 2'b01 : 2'b10), 5'd1, rg};
        if (wr) begin
            e.exp_o  = {pre, hdr, 2'b10, wd};
            e.mask_o = '1;
            e.exp_oe = {pre, 32'hFFFF_FFFF};
            e.rdata  = 16'h0;
            e.err    = 1'b0;
        end else begin
            e.exp_o  = {pre, hdr, 18'h0};
            e.mask_o = ~64'h3FFFF;
            e.exp_oe = {pre, 14'h3FFF, 18'h0};
            e.rdata  = pen ? pd : 16'hFFFF;
            e.err    = !pen || ta;
        end
        e.nbits = full ? 64 : 32;
        e.lat   = e.nbits * 2 * CLK_DIV + 1;
        sb.push_back(e);
        phy_en  = pen;
        phy_pat = {46'h3FFF_FFFF_FFFF, 1'b1, ta, pd};
        pre_off = full ? 0 : 32;
    endtask

    task automatic issue(input logic wr, input logic [4:0] rg, input logic [15:0] wd,
                         input logic pen, input logic ta, input logic [15:0] pd);
        push_exp(wr, rg, wd, pen, ta, pd);
        req_write = wr;
        req_reg   = rg;
        req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk); #2;
        req_valid = 1'b0;
        check("accepted", 64'(req_ready), 64'd0);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 2000 && sb.size() != 0; i++)
            @(posedge clk);
        check(tag, 64'(sb.size()), 64'd0);
        @(posedge clk); #2;
    endtask

    initial begin
        int unsigned abort_bit;
        int          gap;

        // Reset values
        repeat (3) @(posedge clk);
        #2;
        check("rst_mdc", 64'(mdc), 64'd0);
        check("rst_mdio_o", 64'(mdio_o), 64'd1);
        check("rst_mdio_oe", 64'(mdio_oe), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd1);

        // Write reg 0 issued together with reset release: accepted on the first edge
        @(posedge clk); #2;
        rstn = 1'b1;
        issue(1'b1, 5'd0, 16'h2100, 1'b0, 1'b0, 16'h0);
        wait_done("wr0_timeout");
        check("idle_mdio_oe", 64'(mdio_oe), 64'd0);
        check("idle_mdio_o", 64'(mdio_o), 64'd1);
        check("idle_mdc", 64'(mdc), 64'd0);

        // Read reg 1 with PHY answering 786D
        issue(1'b0, 5'd1, 16'hDEAD, 1'b1, 1'b0, 16'h786D);
        wait_done("rd1_timeout");

        // Read reg 2 with no PHY: bus floats high
        issue(1'b0, 5'd2, 16'h0, 1'b0, 1'b0, 16'h0);
        wait_done("rd2_timeout");

        // Reset mid-frame
`ifdef MDIO_PREAMBLE_SKIP_EN
        abort_bit = 20;
`else
        abort_bit = 40;
`endif
        issue(1'b1, 5'd3, 16'hA5A5, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 1000 && k < abort_bit; i++)
            @(posedge clk);
        check("abort_reached", 64'(k), 64'(abort_bit));
        #1;
        rstn = 1'b0;
        #1;
        check("abort_mdc", 64'(mdc), 64'd0);
        check("abort_mdio_oe", 64'(mdio_oe), 64'd0);
        check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        check("abort_req_ready", 64'(req_ready), 64'd1);
        sb.delete();
        first_frame = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b1;
        repeat (300) @(posedge clk);
        #2;
        issue(1'b1, 5'd4, 16'h1234, 1'b0, 1'b0, 16'h0);
        wait_done("post_abort_timeout");

        // Back-to-back with req_valid held; inputs change mid-frame to the second request
        push_exp(1'b1, 5'd5, 16'h0F0F, 1'b0, 1'b0, 16'h0);
        push_exp(1'b1, 5'd6, 16'hF0F0, 1'b0, 1'b0, 16'h0);
        req_write = 1'b1;
        req_reg   = 5'd5;
        req_wdata = 16'h0F0F;
        req_valid = 1'b1;
        @(posedge clk); #2;
        check("b2b_first_accept", 64'(req_ready), 64'd0);
        repeat (20) @(posedge clk);
        #2;
        req_reg   = 5'd6;
        req_wdata = 16'hF0F0;
        for (int i = 0; i < 1000 && sb.size() > 1; i++)
            @(posedge clk);
        #2;
        for (int i = 0; i < 10 && req_ready; i++) begin
            @(posedge clk); #2;
        end
        req_valid = 1'b0;
        check("b2b_second_accept", 64'(req_ready), 64'd0);
        gap = last_acc_cyc - last_rsp_cyc;
        check("b2b_gap", 64'(gap), 64'd1);
        wait_done("b2b_timeout");

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
